// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU decode/issue stage: opcodes, instruction
// field positions, register-file geometry and the operand-select helper.
package alu_issue_pkg;

    localparam int DATA_W   = 16;
    localparam int OP_W     = 4;
    localparam int IMM_W    = 5;
    localparam int RADDR_W  = 3;
    localparam int NUM_REGS = 8;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_RNG = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOP = 4'b1111;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS_LSB  = 6;
    localparam int I_BIT   = 5;
    localparam int RT_LSB  = 2;
    localparam int IMM_LSB = 0;

    // One in-flight pipeline slot (X or W).
    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rd;
    } slot_t;

    // R0 is zero, a result sitting in W beats the (stale) register file.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [RADDR_W-1:0] addr,
        input slot_t              w,
        input logic [DATA_W-1:0]  fwd_data,
        input logic [DATA_W-1:0]  rf_data
    );
        if (addr == '0)
            return '0;
        if (w.valid && (w.rd == addr))
            return fwd_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/regfile8x16.sv
// 8 x 16-bit register file: two async read ports, one debug read port,
// one synchronous write port; R0 always reads as zero and ignores writes.
module regfile8x16
    import alu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] ra_addr_i,
    input  logic [RADDR_W-1:0] rb_addr_i,
    input  logic [RADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]  ra_data_o,
    output logic [DATA_W-1:0]  rb_data_o,
    output logic [DATA_W-1:0]  dbg_data_o,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0]  wd_i
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // NOTE: this is a flop-based file, so the async reset clears every entry;
    // a RAM-style array would instead be left unreset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o  = (ra_addr_i  == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o  = (rb_addr_i  == '0) ? '0 : regs_q[rb_addr_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Decode and operand-fetch stage feeding a registered one-cycle ALU, with a
// single-entry scoreboard, one-cycle interlock and W-stage result forwarding.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [15:0]        instr,
    output logic               instr_ready,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [IMM_W-1:0]   alu_imm,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero,
    input  logic               alu_sign,
    output logic               retire,
    output logic [RADDR_W-1:0] retire_rd,
    output logic               flag_zero,
    output logic               flag_sign,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [OP_W-1:0]    op;
    logic [RADDR_W-1:0] rd, rs, rt;
    logic               imm_sel;
    logic [IMM_W-1:0]   imm;

    assign op      = instr[OP_LSB  +: OP_W];
    assign rd      = instr[RD_LSB  +: RADDR_W];
    assign rs      = instr[RS_LSB  +: RADDR_W];
    assign imm_sel = instr[I_BIT];
    assign rt      = instr[RT_LSB  +: RADDR_W];
    assign imm     = instr[IMM_LSB +: IMM_W];

    slot_t              x_q, x_d, w_q, w_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [IMM_W-1:0]   alu_imm_q, alu_imm_d;
    logic               retire_q, retire_d;
    logic [RADDR_W-1:0] retire_rd_q, retire_rd_d;
    logic               flag_zero_q, flag_zero_d, flag_sign_q, flag_sign_d;

    logic [DATA_W-1:0]  rf_a, rf_b;
    logic               is_nop, hazard, issue;

    regfile8x16 u_regfile (
        .clk        (clk),
        .rst        (rst),
        .ra_addr_i  (rs),
        .rb_addr_i  (rt),
        .dbg_addr_i (dbg_addr),
        .ra_data_o  (rf_a),
        .rb_data_o  (rf_b),
        .dbg_data_o (dbg_data),
        .we_i       (w_q.valid),
        .wa_i       (w_q.rd),
        .wd_i       (alu_result)
    );

    // Only X can conflict: a W producer is covered by the forward.
    assign is_nop = (op > OP_RNG);
    assign hazard = instr_valid && !is_nop && x_q.valid && (x_q.rd != '0) &&
                    ((rs == x_q.rd) || (!imm_sel && (rt == x_q.rd)));
    assign instr_ready = !rst && !hazard;
    assign issue       = instr_valid && instr_ready;

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        alu_op_d    = OP_NOP;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_imm_d   = '0;
        x_d         = '0;
        w_d         = x_q;
        retire_d    = w_q.valid;
        retire_rd_d = retire_rd_q;
        flag_zero_d = flag_zero_q;
        flag_sign_d = flag_sign_q;

        if (issue && !is_nop) begin
            alu_op_d  = op;
            alu_a_d   = select_operand(rs, w_q, alu_result, rf_a);
            alu_b_d   = imm_sel ? '0 : select_operand(rt, w_q, alu_result, rf_b);
            alu_imm_d = imm_sel ? imm : '0;
            x_d       = '{valid: 1'b1, rd: rd};
        end

        if (w_q.valid) begin
            retire_rd_d = w_q.rd;
            flag_zero_d = alu_zero;
            flag_sign_d = alu_sign;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            w_q         <= '0;
            alu_op_q    <= OP_NOP;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_imm_q   <= '0;
            retire_q    <= 1'b0;
            retire_rd_q <= '0;
            flag_zero_q <= 1'b0;
            flag_sign_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            w_q         <= w_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_imm_q   <= alu_imm_d;
            retire_q    <= retire_d;
            retire_rd_q <= retire_rd_d;
            flag_zero_q <= flag_zero_d;
            flag_sign_q <= flag_sign_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_imm   = alu_imm_q;
    assign retire    = retire_q;
    assign retire_rd = retire_rd_q;
    assign flag_zero = flag_zero_q;
    assign flag_sign = flag_sign_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode and operand-fetch stage directly upstream of the 16-bit ALU. It accepts 16-bit instruction words from fetch and holds the 8 × 16-bit register file. It drives the ALU's `op`/`A`/`B`/`Imm` inputs from registers and writes the ALU result back one cycle after the ALU produces it. A single-entry scoreboard, a one-cycle interlock and result forwarding keep dependent instructions correct despite the ALU's registered, one-cycle latency.

## Interface
- No parameters; widths fixed: 16-bit data, 4-bit op, 5-bit imm, 3-bit register address.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: fetch presents `instr`.
- `instr` in 16: instruction word.
- `instr_ready` out 1: instruction accepted this edge when high with `instr_valid`.
- `alu_op` out 4: registered, to ALU `op`.
- `alu_a` out 16: registered, to ALU `A`.
- `alu_b` out 16: registered, to ALU `B`.
- `alu_imm` out 5: registered, to ALU `Imm`; raw bits, the ALU sign-extends.
- `alu_result` in 16: ALU `Output`.
- `alu_zero` in 1: ALU `zero`.
- `alu_sign` in 1: ALU `sign`.
- `retire` out 1: registered pulse when a result is written.
- `retire_rd` out 3: register written on that retire.
- `flag_zero` out 1: registered copy of the ALU `zero` flag captured at retire.
- `flag_sign` out 1: registered copy of the ALU `sign` flag captured at retire.
- `dbg_addr` in 3: combinational register-file read address (bench/debug).
- `dbg_data` out 16: register-file contents at `dbg_addr`.

## Operation
- Encoding: `op`=[15:12], `rd`=[11:9], `rs`=[8:6], `i`=[5].
  - `i`=0: `rt`=[4:2]; issue B=R[rt], imm=0.
  - `i`=1: issue B=0, imm=[4:0].
- Ops 0000–1000 write `rd`.
- Ops 1001–1111 are NOPs:
  - accepted, issued as `alu_op`=1111 (ALU holds `Output`);
  - no writeback, no scoreboard entry.
- `alu_op`=1111 whenever nothing is issued. Op 1000 (RNG) reaches the ALU for exactly one cycle per instruction, because the ALU advances its RNG every cycle op 1000 is held.
- R0 reads as 0. Writes to R0 are discarded, and R0 never causes a hazard.
- Pipeline slots:
  - X: issued last edge, ALU computing now.
  - W: ALU `Output` valid now; written at the next edge.
  - Each slot holds a valid bit and `rd`. X moves to W every cycle.
- Hazard: `instr_valid` and X valid, X.rd≠0, and (`rs`=X.rd, or `i`=0 and `rt`=X.rd).
  - `instr_ready`=!hazard; a NOP never stalls.
  - A stall issues a bubble (op 1111, X invalid).
- Operand select, per source:
  - address 0 → 0;
  - else W valid and address=W.rd → `alu_result`;
  - else R[address].
- Writeback: W valid and W.rd≠0 → R[W.rd]←`alu_result`, `flag_zero`←`alu_zero`, `flag_sign`←`alu_sign`, `retire`=1, `retire_rd`=W.rd.
  - W valid with W.rd=0 still pulses `retire` (`retire_rd`=0) and updates the flags; R0 remains 0.
- Simultaneous writeback and read of the same register: the forward supplies the new value.

## Timing
- Accept at edge E1 → ALU inputs valid after E1.
- ALU `Output` valid after E2; register write, `retire` and flags at E3.
- Back-to-back dependency: one-cycle bubble; the dependent instruction issues at E3 with the forwarded value.
- Distance 2: no stall; operand taken from the W forward.
- Distance ≥3: operand taken from the register file.
- Sustained throughput: one instruction per cycle with no dependencies.
- Reset (asynchronous, any time, including mid-stall):
  - R0–R7=0, X/W invalid;
  - `alu_op`=1111, `alu_a`/`alu_b`=0, `alu_imm`=0;
  - `retire`=0, `retire_rd`=0, flags=0;
  - `instr_ready`=0 while `rst` is high.
  - In-flight instructions are discarded, with no writeback after reset release.
- `instr_ready` is combinational from `instr`/`instr_valid` and X state; fetch must not depend combinationally on it to drive `instr_valid`.

## Structure
- A shared package holds:
  - opcode constants (ADD 0000 … RNG 1000, NOP 1111);
  - instruction field offsets;
  - the register-count constant.
- One sub-module: `regfile8x16`, with 2 async read ports, 1 debug read port, 1 sync write port, asynchronous reset and R0 hardwired to 0.
- Decode, scoreboard, forwarding and the issue registers stay in `alu_issue`.

## Test plan
- Reset, then 0x0225 (ADD r1,r0,#5) → `alu_op`=0000, `alu_a`=0, `alu_imm`=00101; `retire`, `retire_rd`=1 two cycles later; R1=5.
- 0x0225 then 0x0463 (ADD r2,r1,#3) back-to-back → `instr_ready` low 1 cycle, one op-1111 bubble, then `alu_a`=5; R2=8.
- 0x0225, NOP 0xF000, 0x0463 → no stall; `alu_a`=5 from the forward; R2=8.
- Op 1000 issued with 0 cycles of stall → `alu_op`=1000 for exactly one cycle, then 1111.
- ADD r3,r0,#0 (0x0620) → `flag_zero`=1; write to r0 (0x0025) → `dbg_data`@0=0, no hazard on a following read of r0.
- Assert `rst` while stalled → all outputs return to their reset values immediately; no `retire` after release.
